// File: rtl/ctl_pkg.sv
// Shared pause-control types used by the pause controller, player-link and HUD blocks.
package ctl_pkg;

  typedef enum logic [1:0] {
    REASON_NONE   = 2'd0,
    REASON_LOCAL  = 2'd1,
    REASON_REMOTE = 2'd2,
    REASON_RELOAD = 2'd3
  } pause_reason_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_RELOAD = 1'b1
  } pause_state_t;

  // Fixed-priority pause source: local beats remote beats reload.
  function automatic pause_reason_t reason_sel(input logic local_req,
                                               input logic remote_any,
                                               input logic reloading);
    pause_reason_t r;
    if (local_req) begin
      r = REASON_LOCAL;
    end else if (remote_any) begin
      r = REASON_REMOTE;
    end else if (reloading) begin
      r = REASON_RELOAD;
    end else begin
      r = REASON_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/ctl_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output only
// follows the input after DEBOUNCE_CYCLES consecutive differing samples.
module ctl_debounce #(
  parameter int DEBOUNCE_CYCLES = 65000
) (
  input  logic clk,
  input  logic rst,
  input  logic in_raw,
  output logic out_db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          db_r;
  logic [CW-1:0] cnt_r;

  // Synchroniser chain and debounce counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      db_r    <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= in_raw;
      sync2_r <= sync1_r;
      if (sync2_r == db_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        db_r  <= ~db_r;
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign out_db = db_r;

endmodule

// File: rtl/ctl_pause_multi.sv
// Pause controller merging a debounced local switch, remote player requests
// and a timed reload pause into one registered freeze level with its reason.
module ctl_pause_multi
  import ctl_pkg::*;
#(
  parameter int N_REMOTE        = 1,
  parameter int DEBOUNCE_CYCLES = 65000,
  parameter int RELOAD_CYCLES   = 6500000,
  parameter int TOGGLE_MODE     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sw_pause_raw,
  input  logic                no_ammo,
  input  logic [N_REMOTE-1:0] remote_pause,
  output logic                local_pause,
  output logic                pause,
  output logic [1:0]          pause_reason,
  output logic                reload_done
);

  localparam int TW = $clog2(RELOAD_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(RELOAD_CYCLES - 1);

  logic          db_s;
  logic          db_prev_r;
  logic          toggle_r;
  logic          local_req_s;
  logic          remote_any_s;
  logic          counting_s;
  logic          ammo_rise_s;
  logic          no_ammo_prev_r;

  pause_state_t  state_r;
  pause_state_t  state_nxt_s;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_nxt_s;
  logic          done_pend_r;
  logic          done_pend_nxt_s;

  logic          local_pause_r;
  logic          pause_r;
  pause_reason_t reason_r;
  logic          reload_done_r;
  logic          pause_nxt_s;
  pause_reason_t reason_nxt_s;

  ctl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .in_raw(sw_pause_raw),
    .out_db(db_s)
  );

  // Press detector for toggle mode; releases never touch the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_prev_r <= 1'b0;
      toggle_r  <= 1'b0;
    end else begin
      db_prev_r <= db_s;
      if (db_s && !db_prev_r) begin
        toggle_r <= ~toggle_r;
      end
    end
  end

  // Local request source and shared pause qualifiers.
  always_comb begin
    local_req_s = 1'b0;
    if (TOGGLE_MODE != 0) begin
      local_req_s = toggle_r;
    end else begin
      local_req_s = db_s;
    end
    remote_any_s = |remote_pause;
    counting_s   = ~local_req_s & ~remote_any_s;
    ammo_rise_s  = no_ammo & ~no_ammo_prev_r;
  end

  // Reload FSM next state plus next values of the registered outputs.
  always_comb begin
    state_nxt_s     = state_r;
    timer_nxt_s     = timer_r;
    done_pend_nxt_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (ammo_rise_s) begin
          state_nxt_s = ST_RELOAD;
          timer_nxt_s = '0;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RELOAD: begin
        // A user or remote pause freezes the countdown.
        if (counting_s) begin
          if (timer_r == TIMER_LAST) begin
            state_nxt_s     = ST_RUN;
            timer_nxt_s     = '0;
            done_pend_nxt_s = 1'b1;
          end else begin
            timer_nxt_s = timer_r + TW'(1);
          end
        end else begin
          timer_nxt_s = timer_r;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        timer_nxt_s = '0;
      end
    endcase
    pause_nxt_s  = local_req_s | remote_any_s | (state_r == ST_RELOAD);
    reason_nxt_s = reason_sel(local_req_s, remote_any_s, state_r == ST_RELOAD);
  end

  // State, timer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_RUN;
      timer_r        <= '0;
      done_pend_r    <= 1'b0;
      no_ammo_prev_r <= 1'b0;
      local_pause_r  <= 1'b0;
      pause_r        <= 1'b0;
      reason_r       <= REASON_NONE;
      reload_done_r  <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      timer_r        <= timer_nxt_s;
      done_pend_r    <= done_pend_nxt_s;
      no_ammo_prev_r <= no_ammo;
      local_pause_r  <= local_req_s;
      pause_r        <= pause_nxt_s;
      reason_r       <= reason_nxt_s;
      reload_done_r  <= done_pend_r;
    end
  end

  assign local_pause  = local_pause_r;
  assign pause        = pause_r;
  assign pause_reason = reason_r;
  assign reload_done  = reload_done_r;

endmodule
